// File: rtl/letc_core_pkg.sv
// Shared types, AXI response codes and LIMP helper functions for the
// LETC Core AXI front end.
package letc_core_pkg;

  localparam int AXI_ID_W = 4;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } limp_size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_D,
    ST_WR_AW,
    ST_WR_B,
    ST_RESPOND
  } axi_fsm_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

  function automatic logic [3:0] size_to_wstrb(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] strb;
    case (size)
      SIZE_BYTE: strb = 4'b0001 << addr_lo;
      SIZE_HALF: strb = 4'b0011 << addr_lo;
      default:   strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // Requests that must be refused without touching the bus.
  function automatic logic req_is_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
    return (size == SIZE_RSVD) ||
           ((size == SIZE_HALF) && addr_lo[0]) ||
           ((size == SIZE_WORD) && (addr_lo != 2'b00));
  endfunction

  // Both SLVERR and DECERR carry bit 1 set.
  function automatic logic resp_is_error(input logic [1:0] resp);
    return resp[1];
  endfunction

endpackage

// File: rtl/letc_core_axi_fsm_rr_arb.sv
// Two-input round-robin arbiter; the pointer names the preferred port and
// moves to the other port whenever a grant is taken.
module letc_core_axi_fsm_rr_arb (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic       grant_o,
  output logic       grant_valid_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant_o       = req_i[ptr_q] ? ptr_q : ~ptr_q;
    grant_valid_o = |req_i;
    ptr_d         = ptr_q;
    if (advance_i && grant_valid_o) begin
      ptr_d = ~grant_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/letc_core_axi_fsm.sv
// Arbitrates two LIMP requestors onto one AXI4 manager port, one single-beat
// transaction at a time, and returns data/error to the granted requestor.
module letc_core_axi_fsm
  import letc_core_pkg::*;
#(
  parameter int AXI_ID  = 0,
  parameter int PADDR_W = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [1:0]               i_lmp_valid,
  input  logic [1:0]               i_lmp_wen_nren,
  input  logic [1:0][1:0]          i_lmp_size,
  input  logic [1:0][PADDR_W-1:0]  i_lmp_addr,
  input  logic [1:0][31:0]         i_lmp_wdata,
  output logic [1:0]               o_lmp_ready,
  output logic [31:0]              o_lmp_rdata,
  output logic                     o_lmp_illegal,
  output logic [AXI_ID_W-1:0]      o_axi_arid,
  output logic [PADDR_W-1:0]       o_axi_araddr,
  output logic [7:0]               o_axi_arlen,
  output logic [2:0]               o_axi_arsize,
  output logic [1:0]               o_axi_arburst,
  output logic [2:0]               o_axi_arprot,
  output logic                     o_axi_arvalid,
  input  logic                     i_axi_arready,
  input  logic [31:0]              i_axi_rdata,
  input  logic [1:0]               i_axi_rresp,
  input  logic                     i_axi_rlast,
  input  logic                     i_axi_rvalid,
  output logic                     o_axi_rready,
  output logic [AXI_ID_W-1:0]      o_axi_awid,
  output logic [PADDR_W-1:0]       o_axi_awaddr,
  output logic [7:0]               o_axi_awlen,
  output logic [2:0]               o_axi_awsize,
  output logic [1:0]               o_axi_awburst,
  output logic [2:0]               o_axi_awprot,
  output logic                     o_axi_awvalid,
  input  logic                     i_axi_awready,
  output logic [31:0]              o_axi_wdata,
  output logic [3:0]               o_axi_wstrb,
  output logic                     o_axi_wlast,
  output logic                     o_axi_wvalid,
  input  logic                     i_axi_wready,
  input  logic [1:0]               i_axi_bresp,
  input  logic                     i_axi_bvalid,
  output logic                     o_axi_bready
);

  axi_fsm_state_e      state_q, state_d;
  logic                grant_q, grant_d;
  logic                wen_q, wen_d;
  logic [1:0]          size_q, size_d;
  logic [PADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                illegal_q, illegal_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;

  logic                arb_grant, arb_valid, arb_advance;
  logic [1:0]          sel_size;
  logic [PADDR_W-1:0]  sel_addr;
  logic                sel_illegal;
  logic                unused_ok;

  letc_core_axi_fsm_rr_arb u_arb (
    .clk_i         (i_clk),
    .rst_i         (i_rst),
    .req_i         (i_lmp_valid),
    .advance_i     (arb_advance),
    .grant_o       (arb_grant),
    .grant_valid_o (arb_valid)
  );

  // Only the granted port's fields are looked at.
  assign sel_size    = i_lmp_size[arb_grant];
  assign sel_addr    = i_lmp_addr[arb_grant];
  assign sel_illegal = req_is_illegal(sel_size, sel_addr[1:0]);
  assign arb_advance = (state_q == ST_IDLE) && arb_valid;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    wen_d     = wen_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    illegal_d = illegal_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_d   = arb_grant;
          wen_d     = i_lmp_wen_nren[arb_grant];
          size_d    = sel_size;
          addr_d    = sel_addr;
          wdata_d   = i_lmp_wdata[arb_grant];
          illegal_d = sel_illegal;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (sel_illegal) begin
            state_d = ST_RESPOND;
          end else if (i_lmp_wen_nren[arb_grant]) begin
            state_d = ST_WR_AW;
          end else begin
            state_d = ST_RD_A;
          end
        end
      end
      ST_RD_A: begin
        if (i_axi_arready) begin
          state_d = ST_RD_D;
        end
      end
      ST_RD_D: begin
        if (i_axi_rvalid) begin
          rdata_d   = i_axi_rdata;
          illegal_d = resp_is_error(i_axi_rresp);
          state_d   = ST_RESPOND;
        end
      end
      ST_WR_AW: begin
        // AW and W complete independently; move on once both have gone.
        aw_done_d = aw_done_q | i_axi_awready;
        w_done_d  = w_done_q  | i_axi_wready;
        if (aw_done_d && w_done_d) begin
          state_d = ST_WR_B;
        end
      end
      ST_WR_B: begin
        if (i_axi_bvalid) begin
          illegal_d = resp_is_error(i_axi_bresp);
          state_d   = ST_RESPOND;
        end
      end
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= 1'b0;
      wen_q     <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      illegal_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      wen_q     <= wen_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      illegal_q <= illegal_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign o_lmp_ready   = (state_q == ST_RESPOND) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign o_lmp_rdata   = rdata_q;
  assign o_lmp_illegal = illegal_q && (state_q == ST_RESPOND);

  assign o_axi_arid    = AXI_ID_W'(AXI_ID);
  assign o_axi_araddr  = addr_q;
  assign o_axi_arlen   = 8'd0;
  assign o_axi_arsize  = {1'b0, size_q};
  assign o_axi_arburst = AXI_BURST_INCR;
  assign o_axi_arprot  = 3'b000;
  assign o_axi_arvalid = (state_q == ST_RD_A);
  assign o_axi_rready  = (state_q == ST_RD_D);

  assign o_axi_awid    = AXI_ID_W'(AXI_ID);
  assign o_axi_awaddr  = addr_q;
  assign o_axi_awlen   = 8'd0;
  assign o_axi_awsize  = {1'b0, size_q};
  assign o_axi_awburst = AXI_BURST_INCR;
  assign o_axi_awprot  = 3'b000;
  assign o_axi_awvalid = (state_q == ST_WR_AW) && !aw_done_q;
  assign o_axi_wdata   = wdata_q;
  assign o_axi_wstrb   = size_to_wstrb(size_q, addr_q[1:0]);
  assign o_axi_wlast   = 1'b1;
  assign o_axi_wvalid  = (state_q == ST_WR_AW) && !w_done_q;
  assign o_axi_bready  = (state_q == ST_WR_B);

  // Single-beat transfers make RLAST redundant; only resp bit 1 matters.
  assign unused_ok = ^{i_axi_rlast, i_axi_rresp[0], i_axi_bresp[0]};

endmodule

// File: tb/tb_letc_core_axi_fsm.sv
// Scoreboard bench: drivers push expected LIMP responses, a bench-side AXI
// slave logs bus traffic, and a monitor checks every ready pulse.
`timescale 1ns/1ps
module tb_letc_core_axi_fsm;
  import letc_core_pkg::*;

  localparam int PADDR_W = 32;
  localparam int AXI_ID  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]              lmp_valid, lmp_wen;
  logic [1:0][1:0]         lmp_size;
  logic [1:0][31:0]        lmp_addr, lmp_wdata;
  logic [1:0]              lmp_ready;
  logic [31:0]             lmp_rdata;
  logic                    lmp_illegal;
  logic [AXI_ID_W-1:0]     arid, awid;
  logic [31:0]             araddr, awaddr, wdata, rdata;
  logic [7:0]              arlen, awlen;
  logic [2:0]              arsize, awsize, arprot, awprot;
  logic [1:0]              arburst, awburst, rresp, bresp;
  logic [3:0]              wstrb;
  logic arvalid, arready, rlast, rvalid, rready;
  logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  letc_core_axi_fsm #(.AXI_ID(AXI_ID), .PADDR_W(PADDR_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_lmp_valid(lmp_valid), .i_lmp_wen_nren(lmp_wen), .i_lmp_size(lmp_size),
    .i_lmp_addr(lmp_addr), .i_lmp_wdata(lmp_wdata),
    .o_lmp_ready(lmp_ready), .o_lmp_rdata(lmp_rdata), .o_lmp_illegal(lmp_illegal),
    .o_axi_arid(arid), .o_axi_araddr(araddr), .o_axi_arlen(arlen), .o_axi_arsize(arsize),
    .o_axi_arburst(arburst), .o_axi_arprot(arprot), .o_axi_arvalid(arvalid), .i_axi_arready(arready),
    .i_axi_rdata(rdata), .i_axi_rresp(rresp), .i_axi_rlast(rlast), .i_axi_rvalid(rvalid), .o_axi_rready(rready),
    .o_axi_awid(awid), .o_axi_awaddr(awaddr), .o_axi_awlen(awlen), .o_axi_awsize(awsize),
    .o_axi_awburst(awburst), .o_axi_awprot(awprot), .o_axi_awvalid(awvalid), .i_axi_awready(awready),
    .o_axi_wdata(wdata), .o_axi_wstrb(wstrb), .o_axi_wlast(wlast), .o_axi_wvalid(wvalid), .i_axi_wready(wready),
    .i_axi_bresp(bresp), .i_axi_bvalid(bvalid), .o_axi_bready(bready)
  );

  typedef struct {
    logic wen; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata;
    logic legal; logic illegal; logic [31:0] rdata; logic [3:0] strb;
    int issue_cyc; int lat;
  } exp_t;

  typedef struct {
    logic wen; logic [31:0] addr; logic [2:0] size; logic [31:0] wdata; logic [3:0] strb; int resp_cyc;
  } log_t;

  exp_t exp_q[2][$];
  log_t axi_log[$];
  int   done_order[$];
  int   done_cnt[2];
  int   tests = 0, fails = 0, proto_err = 0, cyc = 0;
  int   ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  bit   rand_wait = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Slave memory and response behaviour, shared by slave and model.
  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h1000) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [1:0] resp_model(input logic [31:0] a);
    return a[9:8];
  endfunction

  function automatic exp_t make_exp(input logic w, input logic [1:0] sz, input logic [31:0] a,
                                    input logic [31:0] wd, input int lat);
    exp_t e;
    int nbytes;
    nbytes      = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e.wen       = w; e.size = sz; e.addr = a; e.wdata = wd; e.lat = lat; e.issue_cyc = cyc;
    e.legal     = (sz != 2'b11) && ((a % nbytes) == 0);
    e.illegal   = !e.legal || (resp_model(a) >= 2'd2);
    e.rdata     = mem_model(a);
    e.strb      = 4'(((1 << nbytes) - 1) << a[1:0]);
    return e;
  endfunction

  task automatic chk(input string name, input longint act, input longint expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, lmp_ready, 0);
    chk({tag, "_illegal"}, lmp_illegal, 0);
    chk({tag, "_rdata"}, lmp_rdata, 0);
    chk({tag, "_arvalid"}, arvalid, 0);
    chk({tag, "_rready"}, rready, 0);
    chk({tag, "_awvalid"}, awvalid, 0);
    chk({tag, "_wvalid"}, wvalid, 0);
    chk({tag, "_bready"}, bready, 0);
  endtask

  // Bench-side AXI slave: programmable waits, one transaction at a time.
  int   rd_ph = 0, rd_cnt = 0, aw_ph = 0, aw_cnt = 0, w_ph = 0, w_cnt = 0, b_ph = 0, b_cnt = 0;
  log_t rd_l, wr_l;
  initial begin
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 1;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    forever begin
      @(negedge clk);
      arready = 0; rvalid = 0; awready = 0; wready = 0; bvalid = 0;
      if (rst) begin
        rd_ph = 0; aw_ph = 0; w_ph = 0; b_ph = 0;
        continue;
      end
      if (rd_ph == 2 && arvalid) proto_err++;
      if (aw_ph == 2 && awvalid) proto_err++;
      if (w_ph == 2 && wvalid) proto_err++;
      if (rd_ph == 0 && arvalid) begin
        rd_ph = 1; rd_cnt = rand_wait ? int'($urandom_range(0, 3)) : ar_wait;
      end
      if (rd_ph == 1) begin
        if (rd_cnt == 0) begin
          arready = 1;
          rd_l.wen = 0; rd_l.addr = araddr; rd_l.size = arsize; rd_l.wdata = 0; rd_l.strb = 0;
          if (arlen != 0 || arburst != 2'b01 || arprot != 0 || arid != AXI_ID) proto_err++;
          rd_ph = 2; rd_cnt = rand_wait ? int'($urandom_range(0, 3)) : r_wait;
        end else rd_cnt--;
      end else if (rd_ph == 2) begin
        if (!rready) proto_err++;
        if (rd_cnt == 0) begin
          rvalid = 1; rdata = mem_model(rd_l.addr); rresp = resp_model(rd_l.addr);
          rd_l.resp_cyc = cyc; axi_log.push_back(rd_l); rd_ph = 0;
        end else rd_cnt--;
      end
      if (aw_ph == 0 && awvalid) begin
        aw_ph = 1; aw_cnt = rand_wait ? int'($urandom_range(0, 3)) : aw_wait;
      end
      if (aw_ph == 1) begin
        if (aw_cnt == 0) begin
          awready = 1; wr_l.addr = awaddr; wr_l.size = awsize;
          if (awlen != 0 || awburst != 2'b01 || awprot != 0 || awid != AXI_ID) proto_err++;
          aw_ph = 2;
        end else aw_cnt--;
      end
      if (w_ph == 0 && wvalid) begin
        w_ph = 1; w_cnt = rand_wait ? int'($urandom_range(0, 3)) : w_wait;
      end
      if (w_ph == 1) begin
        if (w_cnt == 0) begin
          wready = 1; wr_l.wdata = wdata; wr_l.strb = wstrb;
          if (!wlast) proto_err++;
          w_ph = 2;
        end else w_cnt--;
      end
      if (aw_ph == 2 && w_ph == 2 && !awready && !wready) begin
        if (!bready) proto_err++;
        if (b_ph == 0) begin
          b_ph = 1; b_cnt = rand_wait ? int'($urandom_range(0, 4)) : b_wait;
        end
        if (b_cnt == 0) begin
          bvalid = 1; bresp = resp_model(wr_l.addr);
          wr_l.wen = 1; wr_l.resp_cyc = cyc; axi_log.push_back(wr_l);
          aw_ph = 0; w_ph = 0; b_ph = 0;
        end else b_cnt--;
      end
    end
  end

  // Monitor: every ready pulse pops the granted port's expectation.
  initial forever begin
    exp_t e;
    log_t l;
    @(negedge clk);
    if (rst) continue;
    if (lmp_ready == 2'b11) chk("ready_onehot", lmp_ready, 2'b01);
    for (int p = 0; p < 2; p++) begin
      if (!lmp_ready[p]) continue;
      if (exp_q[p].size() == 0) begin
        chk($sformatf("unexpected_ready_p%0d", p), 1, 0);
        continue;
      end
      e = exp_q[p].pop_front();
      chk($sformatf("illegal_p%0d", p), lmp_illegal, e.illegal);
      chk("axi_protocol", proto_err, 0);
      if (e.lat >= 0) chk($sformatf("latency_p%0d", p), cyc - e.issue_cyc, e.lat);
      if (!e.legal) begin
        chk("axi_txn_for_illegal", axi_log.size(), 0);
      end else if (axi_log.size() != 1) begin
        chk("axi_txn_count", axi_log.size(), 1);
      end else begin
        l = axi_log.pop_front();
        chk("axi_kind", l.wen, e.wen);
        chk("axi_addr", l.addr, e.addr);
        chk("axi_size", l.size, e.size);
        chk("ready_after_resp", cyc - l.resp_cyc, 1);
        if (e.wen) begin
          chk("axi_wdata", l.wdata, e.wdata);
          chk("axi_wstrb", l.strb, e.strb);
        end else begin
          chk("rdata", lmp_rdata, e.rdata);
        end
      end
      $display("[TB] port%0d %s addr=%08h size=%0d illegal=%0d rdata=%08h cycle=%0d",
               p, e.wen ? "WR" : "RD", e.addr, e.size, lmp_illegal, lmp_rdata, cyc);
      done_order.push_back(p);
      done_cnt[p]++;
    end
  end

  task automatic do_req(input int p, input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input int lat);
    int start;
    bit got;
    lmp_wen[p] = w; lmp_size[p] = sz; lmp_addr[p] = a; lmp_wdata[p] = wd; lmp_valid[p] = 1'b1;
    exp_q[p].push_back(make_exp(w, sz, a, wd, lat));
    start = done_cnt[p];
    got = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(posedge clk); #1;
      if (done_cnt[p] != start) got = 1;
    end
    lmp_valid[p] = 1'b0;
    if (!got) chk($sformatf("timeout_p%0d", p), 0, 1);
  endtask

  task automatic rand_port(input int p, input int n);
    logic [1:0]  sz;
    logic [31:0] a;
    int r;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      r  = $urandom_range(0, 7);
      sz = (r < 2) ? 2'd0 : (r < 4) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
      a  = $urandom & 32'h0000_0FFF;
      if ($urandom_range(0, 3) != 0) a = (sz == 2'd1) ? (a & ~32'h1) : (sz == 2'd2) ? (a & ~32'h3) : a;
      do_req(p, 1'($urandom_range(0, 1)), sz, a, $urandom, -1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    lmp_valid = 0; lmp_wen = 0; lmp_size = 0; lmp_addr = 0; lmp_wdata = 0;
    done_cnt[0] = 0; done_cnt[1] = 0;
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");

    // Both ports valid at reset exit; port0 re-requests at once.
    rst = 0;
    done_order.delete();
    fork
      begin
        do_req(0, 1'b0, 2'd2, 32'h100, 32'h0, 3);
        do_req(0, 1'b1, 2'd2, 32'h104, 32'hCAFE0001, -1);
      end
      do_req(1, 1'b0, 2'd2, 32'h0C0, 32'h0, -1);
    join
    chk("arb_first", done_order.size() > 0 ? done_order[0] : -1, 0);
    chk("arb_second", done_order.size() > 1 ? done_order[1] : -1, 1);
    chk("arb_third", done_order.size() > 2 ? done_order[2] : -1, 0);

    do_req(0, 1'b0, 2'd2, 32'h1000, 32'h0, 3);
    do_req(1, 1'b1, 2'd0, 32'h3, 32'hAB000000, 3);

    aw_wait = 2; w_wait = 0; b_wait = 4;
    do_req(1, 1'b1, 2'd2, 32'h40, 32'h12345678, -1);
    aw_wait = 0; b_wait = 0;

    do_req(0, 1'b0, 2'd2, 32'h2, 32'h0, 1);
    do_req(1, 1'b0, 2'b11, 32'h10, 32'h0, 1);
    do_req(1, 1'b1, 2'd1, 32'h5, 32'h0000FF00, 1);
    do_req(0, 1'b0, 2'd2, 32'h300, 32'h0, 3);
    do_req(1, 1'b1, 2'd1, 32'h206, 32'hBEEF0000, 3);

    // Reset while the read is waiting for R.
    r_wait = 6;
    lmp_wen[0] = 0; lmp_size[0] = 2'd2; lmp_addr[0] = 32'h80; lmp_valid[0] = 1;
    repeat (3) begin @(posedge clk); #1; end
    chk("rd_d_rready", rready, 1);
    chk("rd_d_arvalid", arvalid, 0);
    rst = 1; lmp_valid[0] = 0;
    @(posedge clk); #1;
    check_idle_outputs("midreset");
    rst = 0; r_wait = 0;
    exp_q[0].delete(); exp_q[1].delete(); axi_log.delete();
    do_req(0, 1'b0, 2'd2, 32'h1000, 32'h0, 3);

    rand_wait = 1;
    fork
      rand_port(0, 40);
      rand_port(1, 40);
    join
    repeat (5) begin @(posedge clk); #1; end

    chk("exp_q0_empty", exp_q[0].size(), 0);
    chk("exp_q1_empty", exp_q[1].size(), 0);
    chk("axi_log_empty", axi_log.size(), 0);
    chk("axi_protocol_final", proto_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
